keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// ============================================================================
// Module   : keypad_scan
// Purpose  : 4x4 matrix keypad scanner. Walks a single low drive line across
//            the columns, debounces the synchronized return lines over whole
//            dwell periods, reports one key per press with a valid/ack
//            handshake and tracks release before scanning resumes.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous active-high reset
//            sense_n    - [3:0] keypad return lines, active-low, asynchronous
//            drive_n    - [3:0] keypad drive lines, one bit low at a time
//            key_code   - [7:0] {drive_n, sense_n} of the accepted key
//            key_valid  - key_code holds a new, unacknowledged key
//            key_ack    - consumer acknowledge (sampled only while valid)
//            key_held   - accepted key not yet released
// Options  : KEYPAD_SCAN_MULTI_REJECT_EN - when defined, samples with two or
//            more low return lines are rejected instead of being reduced to
//            their lowest-index low line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
  parameter int SCAN_DIV = 1000,  // clocks per column dwell, 4..65535
  parameter int DEBOUNCE = 4      // consecutive matching samples, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sense_n,
  output logic [3:0] drive_n,
  output logic [7:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REPORT   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] C_DWELL_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  C_MATCH_TARGET = 4'(DEBOUNCE);

  state_t      state_q;
  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [15:0] dwell_q;
  logic [15:0] dwell_d;
  logic [3:0]  match_q;
  logic [3:0]  match_d;
  logic [3:0]  cand_q;
  logic [3:0]  drive_n_q;
  logic [3:0]  drive_rot_d;
  logic [7:0]  key_code_q;
  logic        key_valid_q;
  logic        key_held_q;

  logic        w_dwell_end;
  logic        w_idle;
  logic        w_single;
  logic [3:0]  w_lowest;
  logic        w_key_ok;
  logic [3:0]  w_key;

  assign w_dwell_end = (dwell_q == C_DWELL_LAST);
  assign dwell_d     = w_dwell_end ? 16'd0 : dwell_q + 16'd1;
  assign match_d     = match_q + 4'd1;
  // Left-rotate the single low bit: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  assign drive_rot_d = {drive_n_q[2:0], drive_n_q[3]};

  assign w_idle   = (sync2_q == 4'b1111);
  assign w_single = (sync2_q == 4'b1110) || (sync2_q == 4'b1101) ||
                    (sync2_q == 4'b1011) || (sync2_q == 4'b0111);

  // One-hot-low pattern of the lowest-index low return line.
  always_comb begin
    w_lowest = 4'b1111;
    if (!sync2_q[0]) begin
      w_lowest = 4'b1110;
    end else if (!sync2_q[1]) begin
      w_lowest = 4'b1101;
    end else if (!sync2_q[2]) begin
      w_lowest = 4'b1011;
    end else if (!sync2_q[3]) begin
      w_lowest = 4'b0111;
    end
  end

`ifdef KEYPAD_SCAN_MULTI_REJECT_EN
  // Only a clean single-line sample is a usable key; ghosting combinations
  // are treated like noise.
  assign w_key_ok = w_single;
  assign w_key    = sync2_q;
`else
  // Any pressed pattern is usable once reduced to its lowest-index line; for
  // a single-line sample the reduction is the identity.
  assign w_key_ok = !w_idle;
  assign w_key    = w_lowest;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      dwell_q     <= 16'd0;
      match_q     <= 4'd0;
      cand_q      <= 4'b1111;
      drive_n_q   <= 4'b1110;
      key_code_q  <= 8'hFF;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1_q <= sense_n;
      sync2_q <= sync1_q;
      dwell_q <= dwell_d;

      case (state_q)
        ST_SCAN: begin
          if (w_dwell_end) begin
            if (w_key_ok) begin
              // First hit: drive_n stays on this column from here on.
              cand_q  <= w_key;
              match_q <= 4'd1;
              if (DEBOUNCE == 1) begin
                state_q     <= ST_REPORT;
                key_code_q  <= {drive_n_q, w_key};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= ST_DEBOUNCE;
              end
            end else begin
              drive_n_q <= drive_rot_d;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (w_dwell_end) begin
            if (w_key_ok && (w_key == cand_q)) begin
              match_q <= match_d;
              if (match_d == C_MATCH_TARGET) begin
                state_q     <= ST_REPORT;
                key_code_q  <= {drive_n_q, cand_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end
            end else begin
              match_q   <= 4'd0;
              state_q   <= ST_SCAN;
              drive_n_q <= drive_rot_d;
            end
          end
        end

        ST_REPORT: begin
          // The key stays reported regardless of the lines until consumed.
          if (key_ack) begin
            key_valid_q <= 1'b0;
            match_q     <= 4'd0;
            state_q     <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (w_dwell_end) begin
            if (w_idle) begin
              if (match_d == C_MATCH_TARGET) begin
                match_q    <= 4'd0;
                key_held_q <= 1'b0;
                state_q    <= ST_SCAN;
                drive_n_q  <= drive_rot_d;
              end else begin
                match_q <= match_d;
              end
            end else begin
              match_q <= 4'd0;
            end
          end
        end

        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign drive_n   = drive_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// Module   : tb_keypad_scan
// Purpose  : Directed self-checking bench for keypad_scan with SCAN_DIV=4,
//            DEBOUNCE=2. A small keypad model returns the pressed pattern
//            only while its column is driven; a raw override drives sense_n
//            directly for glitch stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic       clk         = 1'b0;
  logic       rst         = 1'b0;
  logic       key_ack     = 1'b0;
  logic       use_model   = 1'b1;
  logic       pressed     = 1'b0;
  logic [3:0] press_drive = 4'hF;
  logic [3:0] press_sense = 4'hF;
  logic [3:0] raw_sense   = 4'hF;

  logic [3:0] sense_n;
  logic [3:0] drive_n;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sense_n = use_model ? ((pressed && (drive_n == press_drive)) ? press_sense : 4'hF)
                             : raw_sense;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sense_n  (sense_n),
    .drive_n  (drive_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_held (key_held)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!key_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_held_low(input int max_cyc, output int n);
    n = 0;
    while (key_held && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values appear with no clock edge.
    rst = 1'b1;
    #3;
    check8("rst_drive", {4'h0, drive_n}, 8'h0E);
    check8("rst_code", key_code, 8'hFF);
    check1("rst_valid", key_valid, 1'b0);
    check1("rst_held", key_held, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Rotation every 4 clocks, with a stray ack in between.
    repeat (3) @(negedge clk);
    check8("rot_dwell", {4'h0, drive_n}, 8'h0E);
    @(negedge clk);
    check8("rot_1101", {4'h0, drive_n}, 8'h0D);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check1("ack_ignored", key_valid, 1'b0);
    repeat (3) @(negedge clk);
    check8("rot_1011", {4'h0, drive_n}, 8'h0B);
    repeat (4) @(negedge clk);
    check8("rot_0111", {4'h0, drive_n}, 8'h07);
    repeat (4) @(negedge clk);
    check8("rot_1110", {4'h0, drive_n}, 8'h0E);

    // Key on column 0111, return 1110: three columns to reach, then two
    // matching dwell ends.
    press_drive = 4'b0111;
    press_sense = 4'b1110;
    pressed     = 1'b1;
    wait_valid(40, n);
    check8("press_latency", 8'(n), 8'd20);
    check8("press_code", key_code, 8'h7E);
    check1("press_held", key_held, 1'b1);
    check8("press_drive", {4'h0, drive_n}, 8'h07);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check1("hold_valid", key_valid, 1'b1);
      check8("hold_code", key_code, 8'h7E);
    end

    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check1("ack_valid", key_valid, 1'b0);
    check1("ack_held", key_held, 1'b1);
    check8("ack_code_kept", key_code, 8'h7E);

    // Still held: no second report, drive frozen.
    repeat (12) @(negedge clk);
    check1("release_no_valid", key_valid, 1'b0);
    check1("release_held", key_held, 1'b1);
    check8("release_drive", {4'h0, drive_n}, 8'h07);

    pressed = 1'b0;
    wait_held_low(30, n);
    check8("release_latency", 8'(n), 8'd7);
    check8("release_resume", {4'h0, drive_n}, 8'h0E);

    // One-dwell glitch on the raw lines.
    use_model = 1'b0;
    raw_sense = 4'b1101;
    repeat (4) @(negedge clk);
    check8("glitch_freeze", {4'h0, drive_n}, 8'h0E);
    check1("glitch_valid_a", key_valid, 1'b0);
    raw_sense = 4'b1111;
    repeat (4) @(negedge clk);
    check8("glitch_advance", {4'h0, drive_n}, 8'h0D);
    check1("glitch_valid_b", key_valid, 1'b0);

    // Two returns low on column 1011.
    use_model   = 1'b1;
    press_drive = 4'b1011;
    press_sense = 4'b1100;
    pressed     = 1'b1;
`ifdef KEYPAD_SCAN_MULTI_REJECT_EN
    repeat (12) @(negedge clk);
    check1("multi_reject_valid", key_valid, 1'b0);
    check8("multi_reject_drive", {4'h0, drive_n}, 8'h0E);
    pressed = 1'b0;
`else
    repeat (11) @(negedge clk);
    check1("multi_pre_valid", key_valid, 1'b0);
    @(negedge clk);
    check1("multi_valid", key_valid, 1'b1);
    check8("multi_code", key_code, 8'hBE);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check1("multi_ack", key_valid, 1'b0);
    pressed = 1'b0;
    wait_held_low(30, n);
`endif
    check1("multi_held_clear", key_held, 1'b0);

    // Reset in the middle of a report.
    press_drive = 4'b1101;
    press_sense = 4'b0111;
    pressed     = 1'b1;
    wait_valid(60, n);
    check1("rpt2_valid", key_valid, 1'b1);
    check8("rpt2_code", key_code, 8'hD7);
    rst = 1'b1;
    #1;
    check1("midrst_valid", key_valid, 1'b0);
    check8("midrst_code", key_code, 8'hFF);
    check8("midrst_drive", {4'h0, drive_n}, 8'h0E);
    check1("midrst_held", key_held, 1'b0);
    pressed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check8("post_rst_rot", {4'h0, drive_n}, 8'h0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
